// File: rtl/spi_xfer_queue.sv
// spi_xfer_queue
// Byte queue in front of an SPI master. Bytes written into the TX FIFO are
// launched one at a time toward the master. The byte it returns is stored in
// the RX FIFO. A transfer is started only when the RX FIFO has room, so RX
// can never overflow. A transfer that gets no response sets a sticky timeout
// flag and stores nothing.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   tx_wr_en, tx_wr_data      push one byte into the TX FIFO
//   tx_full, tx_count         TX FIFO status
//   rx_rd_en                  pop the RX FIFO head
//   rx_rd_data                RX FIFO head (first-word-fall-through)
//   rx_empty, rx_count        RX FIFO status
//   spi_send_enable           one-cycle launch pulse to the SPI master
//   spi_send_data             byte being sent; held until the next launch
//   spi_rx_data               byte returned by the SPI master
//   spi_rx_valid              master receive strobe; only its rising edge counts
//   busy                      a transfer is in progress
//   timeout_err, err_clr      sticky timeout flag and its clear
module spi_xfer_queue #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_wr_en,
    input  logic [7:0]             tx_wr_data,
    output logic                   tx_full,
    output logic [$clog2(DEPTH):0] tx_count,
    input  logic                   rx_rd_en,
    output logic [7:0]             rx_rd_data,
    output logic                   rx_empty,
    output logic [$clog2(DEPTH):0] rx_count,
    output logic                   spi_send_enable,
    output logic [7:0]             spi_send_data,
    input  logic [7:0]             spi_rx_data,
    input  logic                   spi_rx_valid,
    output logic                   busy,
    output logic                   timeout_err,
    input  logic                   err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_STORE
    } state_t;

    state_t state_reg, state_next;

    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic [CW-1:0] tx_count_reg;
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic [CW-1:0] rx_count_reg;

    logic [TW-1:0] wait_cnt_reg, wait_cnt_inc;
    logic [7:0]    send_data_reg, rx_capture_reg;
    logic          rx_valid_prev_reg, timeout_err_reg;

    logic tx_push, tx_pop, rx_push, rx_pop;
    logic capture, timeout_set, rx_valid_rise;

    // A push into a full TX FIFO is accepted only when the launch pops the
    // head in the same cycle.
    assign tx_push       = tx_wr_en && (!tx_full || tx_pop);
    assign rx_pop        = rx_rd_en && !rx_empty;
    assign rx_valid_rise = spi_rx_valid && !rx_valid_prev_reg;
    assign wait_cnt_inc  = wait_cnt_reg + 1'b1;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;
        capture     = 1'b0;
        timeout_set = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if ((tx_count_reg != '0) && (rx_count_reg < DEPTH_C)) begin
                    tx_pop     = 1'b1;
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_next = ST_WAIT;
            ST_WAIT: begin
                // A response arriving in the last allowed cycle still wins
                // over the timeout.
                if (rx_valid_rise) begin
                    capture    = 1'b1;
                    state_next = ST_STORE;
                end else if (wait_cnt_inc == TIMEOUT_LAST) begin
                    timeout_set = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_STORE: begin
                rx_push    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Wait counter holds the number of WAIT cycles already spent. It reaches
    // TIMEOUT_CYC-1 on the edge that raises timeout_err. That edge comes
    // TIMEOUT_CYC cycles after the LAUNCH cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg      <= '0;
            rx_valid_prev_reg <= 1'b0;
            send_data_reg     <= 8'h00;
            rx_capture_reg    <= 8'h00;
            timeout_err_reg   <= 1'b0;
        end else begin
            rx_valid_prev_reg <= spi_rx_valid;
            if (state_reg == ST_LAUNCH) begin
                wait_cnt_reg <= '0;
            end else if (state_reg == ST_WAIT) begin
                wait_cnt_reg <= wait_cnt_inc;
            end
            if (tx_pop) begin
                send_data_reg <= tx_mem[tx_rd_ptr_reg];
            end
            if (capture) begin
                rx_capture_reg <= spi_rx_data;
            end
            if (timeout_set) begin
                timeout_err_reg <= 1'b1;
            end else if (err_clr) begin
                timeout_err_reg <= 1'b0;
            end
        end
    end

    // ---------------- TX FIFO ----------------
    always_ff @(posedge clk) begin
        if (!rst && tx_push) begin
            tx_mem[tx_wr_ptr_reg] <= tx_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_count_reg  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count_reg <= tx_count_reg + 1'b1;
                2'b01:   tx_count_reg <= tx_count_reg - 1'b1;
                default: tx_count_reg <= tx_count_reg;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    always_ff @(posedge clk) begin
        if (!rst && rx_push) begin
            rx_mem[rx_wr_ptr_reg] <= rx_capture_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_count_reg  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count_reg <= rx_count_reg + 1'b1;
                2'b01:   rx_count_reg <= rx_count_reg - 1'b1;
                default: rx_count_reg <= rx_count_reg;
            endcase
        end
    end

    // ---------------- Outputs ----------------
    assign tx_full         = (tx_count_reg == DEPTH_C);
    assign tx_count        = tx_count_reg;
    assign rx_empty        = (rx_count_reg == '0);
    assign rx_count        = rx_count_reg;
    assign rx_rd_data      = rx_mem[rx_rd_ptr_reg];
    assign spi_send_enable = (state_reg == ST_LAUNCH);
    assign spi_send_data   = send_data_reg;
    assign busy            = (state_reg != ST_IDLE);
    assign timeout_err     = timeout_err_reg;

endmodule

// File: tb/tb_spi_xfer_queue.sv
// Testbench for spi_xfer_queue: a queue-level reference model checked every
// cycle, an SPI master responder (reply = sent byte ^ 8'h99), and directed
// scenarios with hand-computed literal expectations.
module tb_spi_xfer_queue;
    localparam int DEPTH = 8;
    localparam int T     = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, tx_wr_en, rx_rd_en, spi_rx_valid, err_clr;
    logic [7:0]    tx_wr_data, spi_rx_data;
    logic          tx_full, rx_empty, spi_send_enable, busy, timeout_err;
    logic [CW-1:0] tx_count, rx_count;
    logic [7:0]    rx_rd_data, spi_send_data;

    always #5 clk = ~clk;

    spi_xfer_queue #(.DEPTH(DEPTH), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst),
        .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data),
        .tx_full(tx_full), .tx_count(tx_count),
        .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data),
        .rx_empty(rx_empty), .rx_count(rx_count),
        .spi_send_enable(spi_send_enable), .spi_send_data(spi_send_data),
        .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
        .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    int tests = 0;
    int fails = 0;
    int neg_cnt = 0, launch_cnt = 0, launch_neg = 0, rd_neg = 0;
    logic [7:0] last_sent = 8'h00;
    logic [7:0] resp_byte;
    bit   auto_resp = 1'b0;
    int   resp_delay = 10;
    bit   pop_all = 1'b0;
    int   pop_req = 0, pop_done = 0;
    bit   obs_en = 1'b0;
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];

    // Reference model: transfer phases expressed with queues and edge times
    localparam int P_IDLE = 0, P_LAUNCH = 1, P_WAIT = 2, P_STORE = 3;
    logic [7:0] m_tx[$];
    logic [7:0] m_rx[$];
    int   m_phase = P_IDLE;
    int   m_edge = 0, m_launch_edge = 0;
    logic [7:0] m_send = 8'h00, m_cap = 8'h00;
    bit   m_err = 1'b0, m_prev = 1'b0, m_valid = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit rise, tx_pop, do_push, store, tset;
        int nphase;
        m_edge++;
        if (rst) begin
            m_tx.delete();
            m_rx.delete();
            m_phase = P_IDLE;
            m_send  = 8'h00;
            m_err   = 1'b0;
            m_prev  = 1'b0;
            m_valid = 1'b1;
        end else begin
            rise   = spi_rx_valid && !m_prev;
            nphase = m_phase;
            tx_pop = 1'b0;
            store  = 1'b0;
            tset   = 1'b0;
            case (m_phase)
                P_IDLE: if (m_tx.size() > 0 && m_rx.size() < DEPTH) begin
                    tx_pop = 1'b1;
                    nphase = P_LAUNCH;
                    m_launch_edge = m_edge;
                end
                P_LAUNCH: nphase = P_WAIT;
                P_WAIT: if (rise) begin
                    m_cap  = spi_rx_data;
                    nphase = P_STORE;
                end else if (m_edge - m_launch_edge == T) begin
                    tset   = 1'b1;
                    nphase = P_IDLE;
                end
                default: begin
                    store  = 1'b1;
                    nphase = P_IDLE;
                end
            endcase
            do_push = tx_wr_en && (m_tx.size() < DEPTH || tx_pop);
            if (tx_pop) m_send = m_tx.pop_front();
            if (do_push) m_tx.push_back(tx_wr_data);
            if (rx_rd_en && m_rx.size() > 0) void'(m_rx.pop_front());
            if (store) m_rx.push_back(m_cap);
            if (tset) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            m_prev  = spi_rx_valid;
            m_phase = nphase;
        end
    endtask

    task automatic compare_cycle();
        neg_cnt++;
        if (spi_send_enable) begin
            launch_cnt++;
            launch_neg = neg_cnt;
            last_sent  = spi_send_data;
            $display("[TB] launch %0d data=0x%02h t=%0t", launch_cnt, spi_send_data, $time);
        end
        if (rx_rd_en) rd_neg = neg_cnt;
        if (obs_en && rx_rd_en && !rx_empty) obs_q.push_back(rx_rd_data);
        if (m_valid) begin
            check("tx_count", int'(tx_count), m_tx.size());
            check("tx_full", int'(tx_full), int'(m_tx.size() == DEPTH));
            check("rx_count", int'(rx_count), m_rx.size());
            check("rx_empty", int'(rx_empty), int'(m_rx.size() == 0));
            if (m_rx.size() > 0) check("rx_rd_data", int'(rx_rd_data), int'(m_rx[0]));
            check("spi_send_enable", int'(spi_send_enable), int'(m_phase == P_LAUNCH));
            check("spi_send_data", int'(spi_send_data), int'(m_send));
            check("busy", int'(busy), int'(m_phase != P_IDLE));
            check("timeout_err", int'(timeout_err), int'(m_err));
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        tx_wr_en   = 1'b1;
        tx_wr_data = b;
        sync();
        tx_wr_en   = 1'b0;
    endtask

    task automatic wait_launch(input string name);
        int base;
        bit ok;
        base = launch_cnt;
        ok   = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = (launch_cnt > base);
        end
        check(name, int'(ok), 1);
    endtask

    task automatic wait_rx_full(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            ok = (rx_count == CW'(DEPTH)) && !busy;
        end
        check(name, int'(ok), 1);
    endtask

    task automatic wait_drained(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            ok = (tx_count == '0) && rx_empty && !busy;
        end
        check(name, int'(ok), 1);
    endtask

    initial begin
        int base, ln;
        bit ok;
        logic [7:0] b;
        rst = 1'b1; tx_wr_en = 1'b0; tx_wr_data = 8'h00; rx_rd_en = 1'b0;
        spi_rx_valid = 1'b0; spi_rx_data = 8'h00; err_clr = 1'b0;
        fork
            forever begin
                @(posedge clk);
                model_step();
            end
            forever begin
                @(negedge clk);
                compare_cycle();
            end
            forever begin
                @(negedge clk);
                if (auto_resp && spi_send_enable) begin
                    resp_byte = spi_send_data ^ 8'h99;
                    repeat (resp_delay) @(posedge clk);
                    #1;
                    spi_rx_data  = resp_byte;
                    spi_rx_valid = 1'b1;
                    @(posedge clk);
                    #1;
                    spi_rx_valid = 1'b0;
                end
            end
            forever begin
                @(posedge clk);
                #1;
                if (pop_req != pop_done) begin
                    rx_rd_en = 1'b1;
                    pop_done++;
                end else begin
                    rx_rd_en = pop_all && !rx_empty;
                end
            end
        join_none

        // Reset state
        repeat (3) sync();
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx_count", int'(tx_count), 0);
        check("rst_tx_full", int'(tx_full), 0);
        check("rst_rx_empty", int'(rx_empty), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_send_data", int'(spi_send_data), 0);
        check("rst_timeout_err", int'(timeout_err), 0);

        // Single transfer: A5 out, 3C back after 10 cycles
        auto_resp = 1'b1; resp_delay = 10;
        sync();
        base = launch_cnt;
        push(8'hA5);
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = (rx_count == CW'(1)) && !busy;
        end
        check("single_done", int'(ok), 1);
        check("single_launches", launch_cnt - base, 1);
        check("single_sent", int'(last_sent), 8'hA5);
        check("single_rx_data", int'(rx_rd_data), 8'h3C);
        check("single_rx_count", int'(rx_count), 1);
        check("single_busy", int'(busy), 0);
        pop_req++;
        repeat (3) @(negedge clk);
        check("single_popped", int'(rx_empty), 1);

        // TX overflow while RX is full
        resp_delay = 1;
        sync();
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        wait_rx_full("fill_rx_done");
        sync();
        base = launch_cnt;
        for (int i = 0; i < 9; i++) begin
            tx_wr_en   = 1'b1;
            tx_wr_data = 8'(i + 1);
            sync();
            if (i == 7) check("ovf_full_after_8", int'(tx_full), 1);
        end
        tx_wr_en = 1'b0;
        @(negedge clk);
        check("ovf_tx_count", int'(tx_count), 8);
        check("ovf_tx_full", int'(tx_full), 1);
        check("ovf_no_launch", launch_cnt - base, 0);
        pop_all = 1'b1;
        wait_drained("ovf_drain", 600);
        pop_all = 1'b0;

        // RX full holds off a launch; one pop releases it within 2 cycles
        sync();
        for (int i = 0; i < 9; i++) begin
            tx_wr_en   = 1'b1;
            tx_wr_data = 8'h30 + 8'(i);
            sync();
        end
        tx_wr_en = 1'b0;
        wait_rx_full("hold_rx_full");
        check("hold_tx_count", int'(tx_count), 1);
        base = launch_cnt;
        repeat (20) @(negedge clk);
        check("hold_no_launch", launch_cnt - base, 0);
        pop_req++;
        ok = 1'b0;
        for (int n = 0; n < 6 && !ok; n++) begin
            @(negedge clk);
            ok = (launch_cnt > base);
        end
        check("hold_launch_seen", int'(ok), 1);
        check("hold_launch_latency", launch_neg - rd_neg, 2);
        pop_all = 1'b1;
        wait_drained("hold_drain", 600);

        // Stream 20 bytes with RX popped whenever non-empty
        obs_q.delete();
        exp_q.delete();
        obs_en = 1'b1;
        sync();
        for (int i = 0; i < 20; i++) begin
            ok = 1'b0;
            for (int n = 0; n < 100 && !ok; n++) begin
                ok = !tx_full;
                if (!ok) sync();
            end
            b = 8'(8'h40 + 8'(i * 7));
            exp_q.push_back(b ^ 8'h99);
            push(b);
        end
        wait_drained("stream_drain", 1000);
        obs_en = 1'b0;
        check("stream_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check("stream_byte", (i < obs_q.size()) ? int'(obs_q[i]) : -1, int'(exp_q[i]));
        pop_all = 1'b0;

        // Timeout with no response, then clear
        auto_resp = 1'b0;
        sync();
        push(8'h55);
        wait_launch("to_launch");
        ln = launch_neg;
        ok = 1'b0;
        for (int n = 0; n < T + 10 && !ok; n++) begin
            @(negedge clk);
            ok = timeout_err;
        end
        check("to_flag_set", int'(ok), 1);
        check("to_latency", neg_cnt - ln, T);
        check("to_rx_count", int'(rx_count), 0);
        check("to_busy", int'(busy), 0);
        sync();
        err_clr = 1'b1;
        sync();
        err_clr = 1'b0;
        @(negedge clk);
        check("to_cleared", int'(timeout_err), 0);

        // err_clr held through a timeout: set wins for one cycle
        sync();
        err_clr = 1'b1;
        push(8'h66);
        wait_launch("to2_launch");
        repeat (T + 3) @(negedge clk);
        check("to2_after_clear", int'(timeout_err), 0);
        sync();
        err_clr = 1'b0;

        // Reset during WAIT; late response is ignored
        auto_resp = 1'b1; resp_delay = 10;
        sync();
        push(8'h77);
        wait_launch("rst_launch");
        base = launch_cnt;
        repeat (4) @(negedge clk);
        sync();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("rstw_rx_empty", int'(rx_empty), 1);
        check("rstw_busy", int'(busy), 0);
        check("rstw_send_data", int'(spi_send_data), 0);
        check("rstw_tx_count", int'(tx_count), 0);
        check("rstw_timeout_err", int'(timeout_err), 0);
        check("rstw_no_launch", launch_cnt - base, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_xfer_queue.md
SPI_XFER_QUEUE -- requirements
Module: spi_xfer_queue

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in bytes for each of the TX and RX FIFOs (power of two, 2..64).
REQ-002 Parameter TIMEOUT_CYC, default 1024, maximum clk cycles to wait for a received byte after a launch.
REQ-003 clk  input  1  single clock; every register updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 tx_wr_en  input  1  pushes tx_wr_data into the TX FIFO.
REQ-006 tx_wr_data  input  8  byte to transmit.
REQ-007 tx_full  output  1  TX FIFO holds DEPTH entries.
REQ-008 tx_count  output  $clog2(DEPTH)+1  TX FIFO occupancy.
REQ-009 rx_rd_en  input  1  pops the RX FIFO head.
REQ-010 rx_rd_data  output  8  RX FIFO head, first-word-fall-through; valid when rx_empty=0.
REQ-011 rx_empty  output  1  RX FIFO holds 0 entries.
REQ-012 rx_count  output  $clog2(DEPTH)+1  RX FIFO occupancy.
REQ-013 spi_send_enable  output  1  one-cycle launch pulse to the SPI master data_send_enable input.
REQ-014 spi_send_data  output  8  byte to the SPI master data_send_master input.
REQ-015 spi_rx_data  input  8  byte from the SPI master data_receive_master output.
REQ-016 spi_rx_valid  input  1  SPI master data_receive_master_enable; sampled on rising edge (0->1) only.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 timeout_err  output  1  sticky flag; set on a transfer timeout.
REQ-019 err_clr  input  1  clears timeout_err.

Function
REQ-020 FSM states: IDLE, LAUNCH, WAIT, STORE.
REQ-021 IDLE -> LAUNCH when TX is not empty and RX has at least one free slot (rx_count < DEPTH); the TX head is popped on that transition and registered into spi_send_data.
REQ-022 LAUNCH lasts exactly one cycle with spi_send_enable=1, then moves to WAIT; the wait counter clears to 0.
REQ-023 WAIT: the counter increments each cycle; on a spi_rx_valid rising edge, spi_rx_data is captured and the FSM moves to STORE.
REQ-024 WAIT: if the counter reaches TIMEOUT_CYC-1 without a rising edge, timeout_err is set, no RX push occurs, and the FSM returns to IDLE.
REQ-025 STORE: pushes the captured byte into the RX FIFO in one cycle, then returns to IDLE; because of REQ-021, RX cannot overflow.
REQ-026 Minimum latency from tx_wr_en (FIFO empty, FSM idle) to spi_send_enable: 2 cycles.
REQ-027 Minimum latency from the spi_rx_valid rising edge to rx_empty=0: 2 cycles.
REQ-028 spi_send_data holds its value from LAUNCH until the next LAUNCH.
REQ-029 A push to a full TX FIFO is ignored; tx_count does not change.
REQ-030 A pop from an empty RX FIFO is ignored; the read pointer does not move.
REQ-031 FIFOs are circular; pointers wrap modulo DEPTH, and occupancy distinguishes full from empty.
REQ-032 Simultaneous push and pop on the same FIFO:
- Non-full, non-empty: both take effect; count is unchanged.
- Empty: only the push takes effect.
- Full: for TX, the internal pop and external push both take effect; for RX, the pop and STORE push both take effect.
REQ-033 If err_clr and a timeout set occur in the same cycle, the set wins.
REQ-034 spi_rx_valid edges outside WAIT are ignored; the edge detector still tracks the previous value in every state.

Reset
REQ-035 On rst=1 at a clk edge:
- FSM -> IDLE; both FIFOs emptied (pointers and counts = 0).
- tx_full=0, rx_empty=1, spi_send_enable=0, spi_send_data=8'h00, busy=0, timeout_err=0.
- Wait counter = 0; edge-detect register = 0.
REQ-036 rst asserted mid-transfer, in any state, aborts the transfer without pushing RX; a spi_rx_valid edge arriving after reset is ignored.
REQ-037 rst has priority over all other inputs in the same cycle.

Verification
REQ-038 Push 8'hA5; model the SPI master returning 8'h3C with valid 10 cycles after the launch -> exactly one spi_send_enable pulse with spi_send_data=8'hA5; rx_rd_data=8'h3C, rx_count=1, busy=0.
REQ-039 Push 9 bytes 8'h01..8'h09 back-to-back, DEPTH=8, with the FSM held off by a full RX -> tx_full=1 after 8 pushes; byte 8'h09 is dropped; tx_count=8.
REQ-040 Fill RX with 8 bytes without reading and leave TX holding 1 byte -> no launch occurs; one rx_rd_en -> launch within 2 cycles.
REQ-041 Launch a byte and never assert spi_rx_valid -> timeout_err=1 at TIMEOUT_CYC cycles after LAUNCH, rx_count=0, FSM in IDLE; err_clr -> timeout_err=0.
REQ-042 Assert rst during WAIT, then pulse spi_rx_valid -> all reset values hold and rx_empty=1.
REQ-043 Stream 20 bytes while popping RX on every cycle it is non-empty, forcing pointer wrap and simultaneous push/pop -> the RX output sequence equals the model's response sequence, with no loss or duplication.
